fetch_ctrl: RTL and testbench

//  Instruction-fetch sequencer. Owns the program counter and drives the imem req/gnt/rvalid handshake.

---
 rtl/fetch_ctrl.sv | 124 ++++++++++++
 tb/tb_fetch_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the imem req/gnt/rvalid
// handshake and holds one fetched instruction for decode.
module fetch_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = {DATA_WIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  if_valid,
    output logic [DATA_WIDTH-1:0] if_pc,
    output logic [DATA_WIDTH-1:0] if_instr,
    input  logic                  id_ready,
    output logic                  misalign_o,
    output logic [31:0]           fetch_cnt
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pc_next;
    logic                  kill;
    logic                  kill_next;
    logic                  latch_instr;
    logic                  consume;
    logic [DATA_WIDTH-1:0] target_pc;

    assign target_pc = {redirect_pc[DATA_WIDTH-1:2], 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= BOOT;
            pc         <= RESET_VECTOR;
            kill       <= 1'b0;
            if_pc      <= {DATA_WIDTH{1'b0}};
            if_instr   <= {DATA_WIDTH{1'b0}};
            misalign_o <= 1'b0;
            fetch_cnt  <= 32'd0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            kill       <= kill_next;
            misalign_o <= redirect_i && (state != BOOT) && (redirect_pc[1:0] != 2'b00);
            if (latch_instr) begin
                if_pc    <= pc;
                if_instr <= imem_rdata;
            end
            if (consume) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
        end
    end

    // A redirect that lands while a request is in flight cannot cancel it,
    // so kill marks the returning word to be thrown away.
    always_comb begin
        state_next  = state;
        pc_next     = pc;
        kill_next   = kill;
        latch_instr = 1'b0;
        consume     = 1'b0;
        case (state)
            BOOT: begin
                state_next = REQ;
            end
            REQ: begin
                if (imem_gnt) begin
                    state_next = RESP;
                    kill_next  = redirect_i;
                end
                if (redirect_i) begin
                    pc_next = target_pc;
                end
            end
            RESP: begin
                if (imem_rvalid) begin
                    if (kill || redirect_i) begin
                        state_next = REQ;
                        kill_next  = 1'b0;
                    end else begin
                        state_next  = HOLD;
                        latch_instr = 1'b1;
                    end
                end else if (redirect_i) begin
                    kill_next = 1'b1;
                end
                if (redirect_i) begin
                    pc_next = target_pc;
                end
            end
            HOLD: begin
                if (redirect_i) begin
                    state_next = REQ;
                    pc_next    = target_pc;
                end else if (id_ready) begin
                    state_next = REQ;
                    pc_next    = pc + DATA_WIDTH'(4);
                    consume    = 1'b1;
                end
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    assign imem_req  = (state == REQ);
    assign imem_addr = pc;
    assign if_valid  = (state == HOLD);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: drives a one-outstanding memory responder and
// checks fetch ordering, stalls, redirects, wrap-around and reset.
module tb_fetch_ctrl;

    localparam logic [31:0] DATA_KEY = 32'h1357_9BDF;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_i;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        id_ready;
    logic        misalign_o;
    logic [31:0] fetch_cnt;

    logic        w_imem_req;
    logic [31:0] w_imem_addr;
    logic        w_if_valid;
    logic [31:0] w_if_pc;
    logic [31:0] w_if_instr;
    logic        w_misalign;
    logic [31:0] w_fetch_cnt;

    logic        gnt_en;
    logic        rvalid_en;
    logic        pending;
    logic [31:0] pend_addr;

    int checks = 0;
    int errors = 0;

    fetch_ctrl u_dut (
        .clk         (clk),
        .rst         (rst),
        .redirect_i  (redirect_i),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_instr    (if_instr),
        .id_ready    (id_ready),
        .misalign_o  (misalign_o),
        .fetch_cnt   (fetch_cnt)
    );

    // Second copy starts just below the top of the address space to exercise pc wrap.
    fetch_ctrl #(.RESET_VECTOR(32'hFFFF_FFFC)) u_dut_wrap (
        .clk         (clk),
        .rst         (rst),
        .redirect_i  (redirect_i),
        .redirect_pc (redirect_pc),
        .imem_req    (w_imem_req),
        .imem_addr   (w_imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_valid    (w_if_valid),
        .if_pc       (w_if_pc),
        .if_instr    (w_if_instr),
        .id_ready    (id_ready),
        .misalign_o  (w_misalign),
        .fetch_cnt   (w_fetch_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // One clock of the memory responder: grant when enabled, return data the cycle after.
    task automatic applyStimulus();
        logic        next_pending;
        logic [31:0] next_addr;
        imem_rvalid  = pending && rvalid_en;
        imem_rdata   = imem_rvalid ? (pend_addr ^ DATA_KEY) : 32'h0;
        imem_gnt     = gnt_en;
        next_pending = (pending && !rvalid_en) || (imem_req && imem_gnt);
        next_addr    = (imem_req && imem_gnt) ? imem_addr : pend_addr;
        if (rst) next_pending = 1'b0;
        @(posedge clk);
        #1;
        pending   = next_pending;
        pend_addr = next_addr;
    endtask

    task automatic fetchOne(input logic [31:0] addr);
        checkOutput("fetch_req", {31'd0, imem_req}, 32'd1);
        checkOutput("fetch_addr", imem_addr, addr);
        applyStimulus();
        applyStimulus();
        checkOutput("hold_valid", {31'd0, if_valid}, 32'd1);
        checkOutput("hold_pc", if_pc, addr);
        checkOutput("hold_instr", if_instr, addr ^ DATA_KEY);
    endtask

    initial begin
        rst         = 1'b1;
        redirect_i  = 1'b0;
        redirect_pc = 32'h0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        id_ready    = 1'b0;
        gnt_en      = 1'b1;
        rvalid_en   = 1'b1;
        pending     = 1'b0;
        pend_addr   = 32'h0;

        applyStimulus();
        applyStimulus();
        checkOutput("rst_req", {31'd0, imem_req}, 32'd0);
        checkOutput("rst_valid", {31'd0, if_valid}, 32'd0);
        checkOutput("rst_cnt", fetch_cnt, 32'd0);
        checkOutput("rst_misalign", {31'd0, misalign_o}, 32'd0);

        // In-order streaming with id_ready always high.
        rst      = 1'b0;
        id_ready = 1'b1;
        applyStimulus();
        fetchOne(32'h0);
        checkOutput("wrap_hold_pc", w_if_pc, 32'hFFFF_FFFC);
        applyStimulus();
        checkOutput("cnt_1", fetch_cnt, 32'd1);
        checkOutput("wrap_next_addr", w_imem_addr, 32'h0);
        fetchOne(32'h4);
        applyStimulus();
        fetchOne(32'h8);
        applyStimulus();
        checkOutput("cnt_3", fetch_cnt, 32'd3);

        // Decode stall: buffer must stay put and no new request issued.
        id_ready = 1'b0;
        fetchOne(32'hC);
        for (int i = 0; i < 5; i++) begin
            applyStimulus();
            checkOutput("stall_valid", {31'd0, if_valid}, 32'd1);
            checkOutput("stall_pc", if_pc, 32'hC);
            checkOutput("stall_instr", if_instr, 32'hC ^ DATA_KEY);
            checkOutput("stall_req", {31'd0, imem_req}, 32'd0);
        end
        id_ready = 1'b1;
        applyStimulus();
        checkOutput("cnt_4", fetch_cnt, 32'd4);

        // Redirect while waiting for rvalid: returning word is dropped.
        checkOutput("pre_redir_addr", imem_addr, 32'h10);
        applyStimulus();
        rvalid_en   = 1'b0;
        redirect_i  = 1'b1;
        redirect_pc = 32'h100;
        applyStimulus();
        checkOutput("resp_redir_req", {31'd0, imem_req}, 32'd0);
        checkOutput("resp_redir_mis", {31'd0, misalign_o}, 32'd0);
        redirect_i = 1'b0;
        rvalid_en  = 1'b1;
        applyStimulus();
        checkOutput("killed_valid", {31'd0, if_valid}, 32'd0);
        fetchOne(32'h100);
        applyStimulus();
        checkOutput("cnt_5", fetch_cnt, 32'd5);

        // Misaligned redirect in HOLD beats id_ready.
        fetchOne(32'h104);
        redirect_i  = 1'b1;
        redirect_pc = 32'h203;
        applyStimulus();
        checkOutput("mis_pulse", {31'd0, misalign_o}, 32'd1);
        checkOutput("mis_valid", {31'd0, if_valid}, 32'd0);
        checkOutput("mis_addr", imem_addr, 32'h200);
        checkOutput("mis_cnt", fetch_cnt, 32'd5);

        // Redirect in REQ without grant just moves the address.
        gnt_en      = 1'b0;
        redirect_pc = 32'h208;
        applyStimulus();
        checkOutput("mis_pulse_end", {31'd0, misalign_o}, 32'd0);
        checkOutput("req_nognt_req", {31'd0, imem_req}, 32'd1);
        checkOutput("req_nognt_addr", imem_addr, 32'h208);

        // Redirect coinciding with grant: the granted fetch is killed.
        gnt_en      = 1'b1;
        redirect_pc = 32'h300;
        applyStimulus();
        checkOutput("req_gnt_req", {31'd0, imem_req}, 32'd0);
        redirect_i = 1'b0;
        applyStimulus();
        checkOutput("req_gnt_valid", {31'd0, if_valid}, 32'd0);
        checkOutput("req_gnt_addr", imem_addr, 32'h300);
        checkOutput("req_gnt_cnt", fetch_cnt, 32'd5);

        // Reset while a response is outstanding.
        applyStimulus();
        rst = 1'b1;
        applyStimulus();
        checkOutput("mid_rst_req", {31'd0, imem_req}, 32'd0);
        checkOutput("mid_rst_valid", {31'd0, if_valid}, 32'd0);
        checkOutput("mid_rst_pc", if_pc, 32'h0);
        checkOutput("mid_rst_instr", if_instr, 32'h0);
        checkOutput("mid_rst_mis", {31'd0, misalign_o}, 32'd0);
        checkOutput("mid_rst_cnt", fetch_cnt, 32'd0);

        // Redirect during BOOT is ignored.
        rst         = 1'b0;
        redirect_i  = 1'b1;
        redirect_pc = 32'h401;
        applyStimulus();
        redirect_i = 1'b0;
        checkOutput("boot_redir_mis", {31'd0, misalign_o}, 32'd0);
        checkOutput("wrap_rst_addr", w_imem_addr, 32'hFFFF_FFFC);
        fetchOne(32'h0);
        applyStimulus();
        checkOutput("post_rst_cnt", fetch_cnt, 32'd1);
        checkOutput("post_rst_addr", imem_addr, 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
